// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one synchronous-read, single-port memory between
// NUM_CH requesters. An access is arbitrated and latched in IDLE or RESP,
// driven to memory for one ISSUE cycle, optionally padded by WAIT states and
// acknowledged in RESP. Latency from request to ack is 2 + WAIT_CYCLES.
// Optional feature macro: ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// when undefined, the lowest channel index always wins.

module mem_bus_arbiter #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_ce_i,
  input  logic [NUM_CH-1:0]          ch_we_i,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_i,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_sel_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
  output logic [DATA_W-1:0]          ch_data_o,
  output logic [NUM_CH-1:0]          ch_ack_o,
  output logic [NUM_CH-1:0]          ch_stall_o,
  output logic                       mem_ce_o,
  output logic                       mem_we_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [DATA_W/8-1:0]        mem_sel_o,
  output logic [DATA_W-1:0]          mem_data_o,
  input  logic [DATA_W-1:0]          mem_data_i
);

  localparam int unsigned SelW = DATA_W / 8;
  localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [ChW-1:0]  grant_q, grant_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Registered memory-side request and the last read value seen.
  logic              mem_ce_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [SelW-1:0]   mem_sel_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [DATA_W-1:0] rdata_q;

  // Arbitration results.
  logic [NUM_CH-1:0] req_mask;
  logic              arb_any;
  logic [ChW-1:0]    win_idx;
  logic              load;

  // Winner's request fields.
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [SelW-1:0]   win_sel;
  logic [DATA_W-1:0] win_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ChW-1:0]      rr_q, rr_d;
  logic [2*NUM_CH-1:0] rot_dbl;
  logic [NUM_CH-1:0]   rot_mask;
  int                  rot_off;
  int                  rr_sum;
  int                  rr_nxt;
`endif

  // Requests eligible this cycle; the channel being acked is still holding ce.
  always_comb begin
    req_mask = ch_ce_i;
    if (state_q == StResp) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant_q == ChW'(i)) req_mask[i] = 1'b0;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin pick: rotate the mask so rr_q lands at bit 0, take the first one.
  always_comb begin
    arb_any  = 1'b0;
    rot_off  = 0;
    rot_dbl  = {req_mask, req_mask} >> rr_q;
    rot_mask = rot_dbl[NUM_CH-1:0];
    for (int i = 0; i < NUM_CH; i++) begin
      if (!arb_any && rot_mask[i]) begin
        arb_any = 1'b1;
        rot_off = i;
      end
    end
    rr_sum = rot_off + int'(rr_q);
    if (rr_sum >= int'(NUM_CH)) rr_sum = rr_sum - int'(NUM_CH);
    win_idx = ChW'(rr_sum);
  end

  // Pointer moves to the channel after each new grant.
  always_comb begin
    rr_nxt = int'(win_idx) + 1;
    if (rr_nxt >= int'(NUM_CH)) rr_nxt = 0;
    rr_d = load ? ChW'(rr_nxt) : rr_q;
  end
`else
  // Fixed priority pick: lowest eligible index wins.
  always_comb begin
    arb_any = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!arb_any && req_mask[i]) begin
        arb_any = 1'b1;
        win_idx = ChW'(i);
      end
    end
  end
`endif

  // Select the winning channel's request fields from the packed buses.
  always_comb begin
    win_we   = 1'b0;
    win_addr = '0;
    win_sel  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_idx == ChW'(i)) begin
        win_we   = ch_we_i[i];
        win_addr = ch_addr_i[i*ADDR_W +: ADDR_W];
        win_sel  = ch_sel_i[i*SelW +: SelW];
        win_data = ch_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // FSM state register plus grant, wait counter and rr pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Next-state logic; WAIT is only entered when wait states are configured.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arb_any) state_d = StIssue;
      end
      StIssue: begin
        cnt_d   = CntW'(WAIT_CYCLES);
        state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StResp;
      end
      StResp: begin
        state_d = arb_any ? StIssue : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state: grant latch strobe, ack pulse, read data, stall.
  always_comb begin
    load     = ((state_q == StIdle) || (state_q == StResp)) && arb_any;
    grant_d  = load ? win_idx : grant_q;
    ch_ack_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ack_o[i] = (state_q == StResp) && (grant_q == ChW'(i));
    end
    // Read data is forwarded straight from memory during a read ack.
    ch_data_o  = ((state_q == StResp) && !mem_we_q) ? mem_data_i : rdata_q;
    ch_stall_o = ch_ce_i & ~ch_ack_o;
  end

  // Memory-side request registers and held read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ce_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_sel_q  <= '0;
      mem_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      mem_ce_q <= load;
      if (load) begin
        mem_we_q   <= win_we;
        mem_addr_q <= win_addr;
        mem_sel_q  <= win_sel;
        mem_data_q <= win_data;
      end
      if ((state_q == StResp) && !mem_we_q) rdata_q <= mem_data_i;
    end
  end

  assign mem_ce_o   = mem_ce_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_sel_o  = mem_sel_q;
  assign mem_data_o = mem_data_q;

endmodule
